// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer with one-entry valid/ready output stage
//
// Ports:
//   clk_in, rst_n_in          clock, synchronous active-low reset
//   rom_addr_out/rom_data_in  combinational ROM read, address is the PC register
//   start_in, halt_in         run control (start pulse, halt level)
//   redirect_valid_in/addr_in branch/jump target, flushes the output stage
//   inst_valid_out/ready_in   handshake toward decode
//   inst_out, inst_pc_out     registered instruction and its fetch address
//   state_out                 IDLE=0, RUN=1, HALT=2, DONE=3

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module fetch_ctrl #(
  parameter int                 ADDR_W    = 8,
  parameter int                 DATA_W    = `DATA_WIDTH,
  parameter logic [ADDR_W-1:0]  RESET_PC  = 8'h00,
  parameter logic [ADDR_W-1:0]  LAST_ADDR = 8'hFF
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  output logic [ADDR_W-1:0] rom_addr_out,
  input  logic [DATA_W-1:0] rom_data_in,
  input  logic              start_in,
  input  logic              halt_in,
  input  logic              redirect_valid_in,
  input  logic [ADDR_W-1:0] redirect_addr_in,
  output logic              inst_valid_out,
  input  logic              inst_ready_in,
  output logic [DATA_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc_out,
  output logic [1:0]        state_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;

  logic stage_free;
  logic fetch;

  // The stage is free when empty or being drained this cycle. inst_ready_in
  // only gates register updates, never the ROM address.
  assign stage_free = !valid_q || inst_ready_in;
  assign fetch      = (state_q == ST_RUN) && !halt_in && !redirect_valid_in && stage_free;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;

    if (redirect_valid_in) begin
      // Flush drops the held instruction even if decode accepts it this cycle.
      pc_d    = redirect_addr_in;
      valid_d = 1'b0;
      if (state_q == ST_DONE) state_d = ST_HALT;
    end else begin
      if (valid_q && inst_ready_in) valid_d = 1'b0;

      if (fetch) begin
        inst_d  = rom_data_in;
        ipc_d   = pc_q;
        valid_d = 1'b1;
        if (pc_q == LAST_ADDR) state_d = ST_DONE;
        else                   pc_d    = pc_q + ADDR_W'(1);
      end

      unique case (state_q)
        ST_IDLE: if (start_in && !halt_in) state_d = ST_RUN;
        ST_RUN:  if (halt_in)              state_d = ST_HALT;
        ST_HALT: if (start_in && !halt_in) state_d = ST_RUN;
        ST_DONE: if (start_in) begin
          state_d = ST_RUN;
          pc_d    = RESET_PC;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      inst_q  <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
    end
  end

  assign rom_addr_out   = pc_q;
  assign inst_valid_out = valid_q;
  assign inst_out       = inst_q;
  assign inst_pc_out    = ipc_q;
  assign state_out      = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl

module tb_fetch_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_n_in, start_in, halt_in, redirect_valid_in, inst_ready_in;
  logic [7:0]  redirect_addr_in;

  logic [7:0]  rom_addr_out, inst_pc_out;
  logic [31:0] rom_data_in, inst_out;
  logic        inst_valid_out;
  logic [1:0]  state_out;

  logic [7:0]  rom_addr3, inst_pc3;
  logic [31:0] rom_data3, inst3;
  logic        valid3;
  logic [1:0]  state3;

  int passed = 0;
  int total  = 0;

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] romw(input logic [7:0] a);
    return 32'hA000_0000 | {24'h0, a};
  endfunction

  assign rom_data_in = romw(rom_addr_out);
  assign rom_data3   = romw(rom_addr3);

  fetch_ctrl dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rom_addr_out(rom_addr_out), .rom_data_in(rom_data_in),
    .start_in(start_in), .halt_in(halt_in), .redirect_valid_in(redirect_valid_in),
    .redirect_addr_in(redirect_addr_in), .inst_valid_out(inst_valid_out), .inst_ready_in(inst_ready_in),
    .inst_out(inst_out), .inst_pc_out(inst_pc_out), .state_out(state_out)
  );

  fetch_ctrl #(.LAST_ADDR(8'h03)) dut3 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rom_addr_out(rom_addr3), .rom_data_in(rom_data3),
    .start_in(start_in), .halt_in(halt_in), .redirect_valid_in(redirect_valid_in),
    .redirect_addr_in(redirect_addr_in), .inst_valid_out(valid3), .inst_ready_in(inst_ready_in),
    .inst_out(inst3), .inst_pc_out(inst_pc3), .state_out(state3)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0; start_in = 1'b0; halt_in = 1'b0;
    redirect_valid_in = 1'b0; redirect_addr_in = 8'h00; inst_ready_in = 1'b1;
    tick(); tick();
    rst_n_in = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (inst_valid_out !== 1'b0) $display("FAIL rst_valid: got %b want 0", inst_valid_out); else passed++;
    total++; if (rom_addr_out !== 8'h00) $display("FAIL rst_pc: got %h want 00", rom_addr_out); else passed++;
    total++; if (state_out !== 2'd0) $display("FAIL rst_state: got %0d want 0", state_out); else passed++;
    total++; if (inst_out !== 32'h0) $display("FAIL rst_inst: got %h want 0", inst_out); else passed++;
    total++; if (inst_pc_out !== 8'h00) $display("FAIL rst_ipc: got %h want 00", inst_pc_out); else passed++;
  endtask

  task automatic test_stream();
    do_reset();
    start_in = 1'b1; tick(); start_in = 1'b0;
    total++; if (state_out !== 2'd1 || inst_valid_out !== 1'b0)
      $display("FAIL start_run: got state %0d valid %b want 1/0", state_out, inst_valid_out); else passed++;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (inst_valid_out !== 1'b1 || inst_out !== romw(8'(i)) || inst_pc_out !== 8'(i))
        $display("FAIL stream_%0d: got v%b %h @%h want v1 %h @%h", i, inst_valid_out, inst_out, inst_pc_out, romw(8'(i)), 8'(i));
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    start_in = 1'b1; tick(); start_in = 1'b0;
    tick(); tick();                   // A0 then A1 in the stage
    inst_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (inst_valid_out !== 1'b1 || inst_out !== romw(8'h01) || inst_pc_out !== 8'h01 || rom_addr_out !== 8'h02)
        $display("FAIL bp_hold_%0d: got v%b %h @%h pc %h want v1 %h @01 pc 02", i, inst_valid_out, inst_out, inst_pc_out, rom_addr_out, romw(8'h01));
      else passed++;
    end
    inst_ready_in = 1'b1; tick();
    total++; if (inst_out !== romw(8'h02) || inst_pc_out !== 8'h02 || rom_addr_out !== 8'h03)
      $display("FAIL bp_release: got %h @%h pc %h want %h @02 pc 03", inst_out, inst_pc_out, rom_addr_out, romw(8'h02)); else passed++;
  endtask

  task automatic test_redirect();
    redirect_valid_in = 1'b1; redirect_addr_in = 8'h40; tick();
    redirect_valid_in = 1'b0;
    total++; if (inst_valid_out !== 1'b0 || rom_addr_out !== 8'h40 || state_out !== 2'd1)
      $display("FAIL redir_flush: got v%b pc %h st %0d want v0 pc 40 st 1", inst_valid_out, rom_addr_out, state_out); else passed++;
    tick();
    total++; if (inst_valid_out !== 1'b1 || inst_out !== romw(8'h40) || inst_pc_out !== 8'h40)
      $display("FAIL redir_target: got v%b %h @%h want v1 %h @40", inst_valid_out, inst_out, inst_pc_out, romw(8'h40)); else passed++;
  endtask

  task automatic test_halt();
    halt_in = 1'b1; start_in = 1'b1; tick();
    total++; if (state_out !== 2'd2 || rom_addr_out !== 8'h41 || inst_valid_out !== 1'b0)
      $display("FAIL halt_enter: got st %0d pc %h v%b want st 2 pc 41 v0", state_out, rom_addr_out, inst_valid_out); else passed++;
    start_in = 1'b0; tick();
    total++; if (state_out !== 2'd2 || rom_addr_out !== 8'h41)
      $display("FAIL halt_hold: got st %0d pc %h want st 2 pc 41", state_out, rom_addr_out); else passed++;
    halt_in = 1'b0; start_in = 1'b1; tick(); start_in = 1'b0;
    total++; if (state_out !== 2'd1 || rom_addr_out !== 8'h41 || inst_valid_out !== 1'b0)
      $display("FAIL halt_resume: got st %0d pc %h v%b want st 1 pc 41 v0", state_out, rom_addr_out, inst_valid_out); else passed++;
    tick();
    total++; if (inst_out !== romw(8'h41) || inst_pc_out !== 8'h41 || inst_valid_out !== 1'b1)
      $display("FAIL halt_refetch: got v%b %h @%h want v1 %h @41", inst_valid_out, inst_out, inst_pc_out, romw(8'h41)); else passed++;
  endtask

  task automatic test_done();
    do_reset();
    start_in = 1'b1; tick(); start_in = 1'b0;
    tick(); tick(); tick(); tick();   // fetch 0..3 on the short-program instance
    total++; if (state3 !== 2'd3 || rom_addr3 !== 8'h03 || valid3 !== 1'b1 || inst3 !== romw(8'h03))
      $display("FAIL done_enter: got st %0d pc %h v%b %h want st 3 pc 03 v1 %h", state3, rom_addr3, valid3, inst3, romw(8'h03)); else passed++;
    tick();
    total++; if (state3 !== 2'd3 || rom_addr3 !== 8'h03 || valid3 !== 1'b0)
      $display("FAIL done_drain: got st %0d pc %h v%b want st 3 pc 03 v0", state3, rom_addr3, valid3); else passed++;
    start_in = 1'b1; tick(); start_in = 1'b0;
    total++; if (state3 !== 2'd1 || rom_addr3 !== 8'h00)
      $display("FAIL done_restart: got st %0d pc %h want st 1 pc 00", state3, rom_addr3); else passed++;
    tick();
    total++; if (valid3 !== 1'b1 || inst3 !== romw(8'h00) || inst_pc3 !== 8'h00)
      $display("FAIL done_refetch: got v%b %h @%h want v1 %h @00", valid3, inst3, inst_pc3, romw(8'h00)); else passed++;
    tick(); tick(); tick();           // fetch 1..3, DONE again
    redirect_valid_in = 1'b1; redirect_addr_in = 8'h01; start_in = 1'b1; tick();
    redirect_valid_in = 1'b0; start_in = 1'b0;
    total++; if (state3 !== 2'd2 || rom_addr3 !== 8'h01 || valid3 !== 1'b0)
      $display("FAIL done_redirect: got st %0d pc %h v%b want st 2 pc 01 v0", state3, rom_addr3, valid3); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    start_in = 1'b1; tick(); start_in = 1'b0;
    redirect_valid_in = 1'b1; redirect_addr_in = 8'h20; tick();
    redirect_valid_in = 1'b0;
    tick(); tick();
    total++; if (rom_addr_out !== 8'h22 || inst_valid_out !== 1'b1 || inst_out !== romw(8'h21))
      $display("FAIL mid_pre: got pc %h v%b %h want pc 22 v1 %h", rom_addr_out, inst_valid_out, inst_out, romw(8'h21)); else passed++;
    rst_n_in = 1'b0; start_in = 1'b1; tick();
    start_in = 1'b0;
    total++; if (inst_valid_out !== 1'b0 || rom_addr_out !== 8'h00 || state_out !== 2'd0 || inst_out !== 32'h0)
      $display("FAIL mid_reset: got v%b pc %h st %0d %h want v0 pc 00 st 0 0", inst_valid_out, rom_addr_out, state_out, inst_out); else passed++;
    rst_n_in = 1'b1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_done();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
